// File: rtl/cpu_io_uart_tx.sv
// Console output path for the CPU's memory-mapped port: each 64-bit io_write word
// is queued in a small FIFO and sent as 8 bytes, LSB byte first, on an 8N1 UART line.
module cpu_io_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          io_write,
  input  logic [63:0]                   io_data,
  input  logic                          clr_overflow,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [1:0]                    dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          r_state, w_state_nx;
  logic [BW-1:0]   r_baud, w_baud_nx;
  logic [2:0]      r_bit, w_bit_nx;
  logic [2:0]      r_byte, w_byte_nx;
  logic [63:0]     r_shift, w_shift_nx;
  logic            r_tx, w_tx_nx;
  logic            r_busy;
  logic            r_overflow;
  logic [CW-1:0]   r_count, w_count_nx;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [63:0]     r_mem [FIFO_DEPTH];

  logic            w_full, w_push, w_pop, w_baud_end;
  logic [2:0]      w_bit_inc;
  logic [7:0]      w_cur_byte;

  // io_write has no backpressure: a word offered while full is dropped and flagged.
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_push     = io_write && !w_full;
  assign w_pop      = (r_state == IDLE) && (r_count != '0);
  assign w_baud_end = (r_baud == BW'(CLKS_PER_BIT - 1));
  assign w_bit_inc  = r_bit + 3'd1;
  assign w_cur_byte = r_shift[7:0];

  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_nx = r_count + 1'b1;
      2'b01:   w_count_nx = r_count - 1'b1;
      default: w_count_nx = r_count;
    endcase
  end

  // tx is computed for the state/bit being entered so each bit is exactly CLKS_PER_BIT wide.
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud + 1'b1;
    w_bit_nx   = r_bit;
    w_byte_nx  = r_byte;
    w_shift_nx = r_shift;
    w_tx_nx    = r_tx;
    case (r_state)
      IDLE: begin
        w_baud_nx = '0;
        w_tx_nx   = 1'b1;
        if (w_pop) begin
          w_shift_nx = r_mem[r_rd_ptr];
          w_byte_nx  = 3'd0;
          w_state_nx = START;
          w_tx_nx    = 1'b0;
        end
      end
      START: begin
        if (w_baud_end) begin
          w_baud_nx  = '0;
          w_bit_nx   = 3'd0;
          w_state_nx = DATA;
          w_tx_nx    = w_cur_byte[0];
        end
      end
      DATA: begin
        if (w_baud_end) begin
          w_baud_nx = '0;
          if (r_bit == 3'd7) begin
            w_state_nx = STOP;
            w_tx_nx    = 1'b1;
          end else begin
            w_bit_nx = w_bit_inc;
            w_tx_nx  = w_cur_byte[w_bit_inc];
          end
        end
      end
      STOP: begin
        if (w_baud_end) begin
          w_baud_nx = '0;
          if (r_byte == 3'd7) begin
            w_state_nx = IDLE;
            w_byte_nx  = 3'd0;
            w_tx_nx    = 1'b1;
          end else begin
            w_byte_nx  = r_byte + 3'd1;
            w_shift_nx = r_shift >> 8;
            w_state_nx = START;
            w_tx_nx    = 1'b0;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_baud_nx  = '0;
        w_tx_nx    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_baud   <= w_baud_nx;
      r_bit    <= w_bit_nx;
      r_byte   <= w_byte_nx;
      r_shift  <= w_shift_nx;
      r_tx     <= w_tx_nx;
      r_busy   <= (w_state_nx != IDLE) || (w_count_nx != '0);
      r_count  <= w_count_nx;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (io_write && w_full) r_overflow <= 1'b1;
      else if (clr_overflow)  r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= io_data;
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_cpu_io_uart_tx.sv
// Directed bench for cpu_io_uart_tx: line-level frame capture compared against
// expected 8N1 waveforms built from the written words.
module tb_cpu_io_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int LW    = 80 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_write = 1'b0;
  logic [63:0] io_data = '0;
  logic        clr_overflow = 1'b0;
  logic        tx, busy, overflow;
  logic [2:0]  fifo_count;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  cpu_io_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .io_write     (io_write),
    .io_data      (io_data),
    .clr_overflow (clr_overflow),
    .tx           (tx),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  // Expected line waveform for one word, one entry per clock cycle from the start-bit edge.
  function automatic logic [LW-1:0] make_line(input logic [63:0] w);
    logic [LW-1:0] l;
    logic b;
    l = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 10; j++) begin
        if (j == 0)      b = 1'b0;
        else if (j == 9) b = 1'b1;
        else             b = w[i*8 + j - 1];
        for (int c = 0; c < CPB; c++) l[(i*10 + j)*CPB + c] = b;
      end
    end
    return l;
  endfunction

  // Waits (bounded) for tx low, then records LW consecutive negedge samples.
  task automatic capture_word(output logic [LW-1:0] line, output int n_wait, output bit timed_out);
    line = '0;
    n_wait = 0;
    timed_out = 1'b0;
    while (tx !== 1'b0 && n_wait < 3000) begin
      @(negedge clk);
      n_wait++;
    end
    if (tx !== 1'b0) begin
      timed_out = 1'b1;
      return;
    end
    line[0] = tx;
    for (int k = 1; k < LW; k++) begin
      @(negedge clk);
      line[k] = tx;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_values: tx=%b busy=%b cnt=%0d ovf=%b st=%0d, want tx=1 busy=0 cnt=0 ovf=0 st=0",
               tx, busy, fifo_count, overflow, dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle_line(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      io_data = {$urandom, $urandom};
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
    end
    io_data = '0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_line_%s: %0d active cycles seen, want 0", tag, bad);
    end
  endtask

  task automatic test_single_word();
    logic [LW-1:0] line;
    logic [63:0]   w;
    int            nw;
    bit            to;
    w = 64'h0123456789ABCDEF;
    io_write = 1'b1; io_data = w;
    @(negedge clk);
    io_write = 1'b0; io_data = '0;
    checks++;
    if (fifo_count !== 3'd1 || busy !== 1'b1 || tx !== 1'b1) begin
      failures++;
      $display("FAIL push_edge: cnt=%0d busy=%b tx=%b, want cnt=1 busy=1 tx=1", fifo_count, busy, tx);
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b0 || fifo_count !== 3'd0 || dbg_state !== 2'd1) begin
      failures++;
      $display("FAIL pop_edge: tx=%b cnt=%0d st=%0d, want tx=0 cnt=0 st=1", tx, fifo_count, dbg_state);
    end
    capture_word(line, nw, to);
    checks++;
    if (to || nw != 0 || line !== make_line(w)) begin
      failures++;
      $display("FAIL single_word: timeout=%b wait=%0d got %h want %h", to, nw, line, make_line(w));
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_last_cycle: busy=%b want 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL busy_drop_320: busy=%b st=%0d ovf=%b, want 0 0 0", busy, dbg_state, overflow);
    end
  endtask

  task automatic test_overflow();
    int exp_cnt [6];
    int exp_ovf [6];
    exp_cnt = '{1, 1, 2, 3, 4, 4};
    exp_ovf = '{0, 0, 0, 0, 0, 1};
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          io_write = 1'b1; io_data = 64'(i + 1);
          @(negedge clk);
          checks++;
          if (fifo_count !== 3'(exp_cnt[i]) || overflow !== 1'(exp_ovf[i])) begin
            failures++;
            $display("FAIL overflow_push%0d: cnt=%0d ovf=%b, want cnt=%0d ovf=%0d",
                     i + 1, fifo_count, overflow, exp_cnt[i], exp_ovf[i]);
          end
        end
        io_write = 1'b0; io_data = '0;
      end
      begin
        logic [LW-1:0] line;
        int nw;
        bit to;
        for (int i = 0; i < 5; i++) begin
          capture_word(line, nw, to);
          checks++;
          if (to || (i > 0 && nw != 2) || line !== make_line(64'(i + 1))) begin
            failures++;
            $display("FAIL overflow_word%0d: timeout=%b wait=%0d got %h want %h",
                     i + 1, to, nw, line, make_line(64'(i + 1)));
          end
        end
      end
    join
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_after_drain: busy=%b tx=%b ovf=%b, want 0 1 1 (word 6 dropped)", busy, tx, overflow);
    end
  endtask

  task automatic test_overflow_clear();
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_held: ovf=%b want 1", overflow);
    end
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: ovf=%b want 0", overflow);
    end
    for (int i = 0; i < 6; i++) begin
      io_write = 1'b1; io_data = 64'h100 + 64'(i);
      @(negedge clk);
    end
    checks++;
    if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL ovf_refill: ovf=%b cnt=%0d, want 1 4", overflow, fifo_count);
    end
    clr_overflow = 1'b1;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL ovf_set_wins: ovf=%b cnt=%0d, want 1 4", overflow, fifo_count);
    end
    io_write = 1'b0; io_data = '0;
    @(negedge clk);
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear_again: ovf=%b want 0", overflow);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] wa, wb;
    wa = 64'hA5A5_0F0F_1234_5678;
    wb = 64'h8000_0000_FFFF_0001;
    fork
      begin
        logic [LW-1:0] la, lb;
        int nw;
        bit to;
        capture_word(la, nw, to);
        checks++;
        if (to || la !== make_line(wa)) begin
          failures++;
          $display("FAIL b2b_word_a: timeout=%b got %h want %h", to, la, make_line(wa));
        end
        capture_word(lb, nw, to);
        checks++;
        if (to || nw != 2) begin
          failures++;
          $display("FAIL b2b_gap: timeout=%b cycles to start=%0d, want 2", to, nw);
        end
        checks++;
        if (lb !== make_line(wb)) begin
          failures++;
          $display("FAIL b2b_word_b: got %h want %h", lb, make_line(wb));
        end
      end
      begin
        io_write = 1'b1; io_data = wa;
        @(negedge clk);
        io_write = 1'b0; io_data = '0;
        repeat (50) @(negedge clk);
        io_write = 1'b1; io_data = wb;
        @(negedge clk);
        io_write = 1'b0; io_data = '0;
        checks++;
        if (fifo_count !== 3'd1) begin
          failures++;
          $display("FAIL b2b_queued: cnt=%0d want 1", fifo_count);
        end
        repeat (100) @(negedge clk);
        checks++;
        if (fifo_count !== 3'd1 || dbg_state === 2'd0) begin
          failures++;
          $display("FAIL b2b_while_shifting: cnt=%0d st=%0d, want cnt=1 st!=0", fifo_count, dbg_state);
        end
      end
    join
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_op();
    io_write = 1'b1; io_data = 64'h0000_0000_0008_0000;
    @(negedge clk);
    io_data = 64'h1111_1111_1111_1111;
    @(negedge clk);
    io_data = 64'h2222_2222_2222_2222;
    @(negedge clk);
    io_write = 1'b0; io_data = '0;
    repeat (96) @(negedge clk);
    checks++;
    if (dbg_state !== 2'd2 || fifo_count !== 3'd2 || tx !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_byte2_bit3: st=%0d cnt=%0d tx=%b busy=%b, want st=2 cnt=2 tx=1 busy=1",
               dbg_state, fifo_count, tx, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset: tx=%b busy=%b cnt=%0d st=%0d, want 1 0 0 0", tx, busy, fifo_count, dbg_state);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_line("after_reset");
    test_single_word();
    test_overflow();
    test_overflow_clear();
    test_back_to_back();
    test_reset_mid_op();
    test_idle_line("after_mid_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
